// File: rtl/alu_pkg.sv
// Shared ALU types: opcode encoding, flag bit positions and the flag bundle.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_AND    = 3'b010,
        OP_OR     = 3'b011,
        OP_XOR    = 3'b100,
        OP_PASS_A = 3'b101,
        OP_PASS_B = 3'b110,
        OP_EXT    = 3'b111
    } alu_op_e;

    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 3;

    // Packed so that the bit order matches {N, V, C, Z}.
    typedef struct packed {
        logic n;
        logic v;
        logic c;
        logic z;
    } alu_flags_t;

endpackage

// File: rtl/alu_if.sv
// ALU operand/result bundle; master drives operands, slave (the ALU) drives results.
interface alu_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             in_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_q;
    logic             out_valid;
    logic [3:0]       flags_q;

    modport master (
        output a, b, op, in_valid,
        input  result, result_q, out_valid, flags_q
    );

    modport slave (
        input  a, b, op, in_valid,
        output result, result_q, out_valid, flags_q
    );

endinterface

// File: rtl/alu_flags.sv
// N/V/C/Z generation from operand sign bits, opcode, result and raw carry.
// ALU_EXT_OPS_EN: op 111 (shift) reports Z/N from result and C from the shift.
module alu_flags
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             a_msb_i,
    input  logic             b_msb_i,
    input  alu_op_e          op_i,
    input  logic [WIDTH-1:0] result_i,
    input  logic             carry_i,
    output logic [3:0]       flags_o
);

    alu_flags_t f;
    logic       r_msb;

    assign r_msb = result_i[WIDTH-1];

    always_comb begin
        f   = '0;
        f.z = (result_i == '0);
        f.n = r_msb;
        unique case (op_i)
            OP_ADD: begin
                f.c = carry_i;
                f.v = (a_msb_i == b_msb_i) && (r_msb != a_msb_i);
            end
            OP_SUB: begin
                // carry_i is the carry of a + ~b + 1, i.e. 1 when there is no borrow.
                f.c = carry_i;
                f.v = (a_msb_i != b_msb_i) && (r_msb != a_msb_i);
            end
            OP_EXT: begin
`ifdef ALU_EXT_OPS_EN
                f.c = carry_i;
`else
                f = '0;
`endif
            end
            default: ;
        endcase
    end

    assign flags_o = f;

endmodule

// File: rtl/alu_core.sv
// Parameterised ALU: combinational result plus a one-cycle registered result/flag stage.
// ALU_EXT_OPS_EN: op 111 becomes a logical shift left of a by b[1:0].
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input logic   clk,
    input logic   rst_n,
    alu_if.slave  bus
);

    alu_op_e          op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic [3:0]       flags;

    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flg_q, flg_d;
    logic             vld_q, vld_d;

    assign op = alu_op_e'(bus.op);

    // Shared adder: SUB is a + ~b + 1.
    assign b_eff = (op == OP_SUB) ? ~bus.b : bus.b;
    assign sum   = {1'b0, bus.a} + {1'b0, b_eff} + (WIDTH + 1)'(op == OP_SUB);

`ifdef ALU_EXT_OPS_EN
    logic [WIDTH:0] shifted;
    // Bit WIDTH of the widened shift is the last bit shifted out.
    assign shifted = {1'b0, bus.a} << bus.b[1:0];
`endif

    always_comb begin
        result = '0;
        carry  = sum[WIDTH];
        unique case (op)
            OP_ADD:    result = sum[WIDTH-1:0];
            OP_SUB:    result = sum[WIDTH-1:0];
            OP_AND:    result = bus.a & bus.b;
            OP_OR:     result = bus.a | bus.b;
            OP_XOR:    result = bus.a ^ bus.b;
            OP_PASS_A: result = bus.a;
            OP_PASS_B: result = bus.b;
            OP_EXT: begin
`ifdef ALU_EXT_OPS_EN
                result = shifted[WIDTH-1:0];
                carry  = shifted[WIDTH];
`else
                result = '0;
`endif
            end
            default: result = '0;
        endcase
    end

    alu_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .a_msb_i  (bus.a[WIDTH-1]),
        .b_msb_i  (bus.b[WIDTH-1]),
        .op_i     (op),
        .result_i (result),
        .carry_i  (carry),
        .flags_o  (flags)
    );

    always_comb begin
        res_d = res_q;
        flg_d = flg_q;
        vld_d = bus.in_valid;
        if (bus.in_valid) begin
            res_d = result;
            flg_d = flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            flg_q <= '0;
            vld_q <= 1'b0;
        end else begin
            res_q <= res_d;
            flg_q <= flg_d;
            vld_q <= vld_d;
        end
    end

    assign bus.result    = result;
    assign bus.result_q  = res_q;
    assign bus.flags_q   = flg_q;
    assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core (WIDTH=4) with a scoreboard of registered results.
module tb_alu_core;

    logic clk;
    logic rst_n;

    alu_if #(.WIDTH(4)) bus();

    alu_core #(
        .WIDTH (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_err = 0;
    int unsigned n_chk = 0;
    logic [7:0]  sb_q[$];
    logic [7:0]  last_cap = '0;
    logic [3:0]  sweep_exp [7] = '{4'd5, 4'd1, 4'd2, 4'd3, 4'd1, 4'd3, 4'd2};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: returns {N, V, C, Z, result[3:0]}.
    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        int sa, sb, s;
        logic [3:0] r;
        logic n, v, c, z;
        sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
        sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'd0: begin
                s = int'(a) + int'(b);
                r = s[3:0];
                c = (s > 15);
                v = (sa + sb > 7) || (sa + sb < -8);
            end
            3'd1: begin
                r = a - b;
                c = (a >= b);
                v = (sa - sb > 7) || (sa - sb < -8);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a;
            3'd6: r = b;
            default: begin
`ifdef ALU_EXT_OPS_EN
                int k;
                k = int'(b[1:0]);
                r = 4'(a << k);
                c = (k == 0) ? 1'b0 : a[4 - k];
`else
                r = '0;
`endif
            end
        endcase
        z = (r == 4'd0);
        n = r[3];
`ifndef ALU_EXT_OPS_EN
        if (op == 3'd7) begin
            z = 1'b0;
            n = 1'b0;
        end
`endif
        return {n, v, c, z, r};
    endfunction

    // One clock: drive at negedge, check comb result, push capture, check registered stage.
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic v);
        logic [7:0] e;
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.op = op;
        bus.in_valid = v;
        #1;
        e = model(a, b, op);
        check_eq("result", bus.result, e[3:0]);
        @(posedge clk);
        if (v) sb_q.push_back(e);
        #1;
        check_eq("out_valid", bus.out_valid, v);
        if (bus.out_valid) begin
            check_eq("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                last_cap = sb_q.pop_front();
                check_eq("result_q", bus.result_q, last_cap[3:0]);
                check_eq("flags_q", bus.flags_q, last_cap[7:4]);
            end
        end else begin
            check_eq("hold_result_q", bus.result_q, last_cap[3:0]);
            check_eq("hold_flags_q", bus.flags_q, last_cap[7:4]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.op = '0;
        bus.in_valid = 1'b0;
        #1;
        check_eq("rst_result_q", bus.result_q, 0);
        check_eq("rst_flags_q", bus.flags_q, 0);
        check_eq("rst_out_valid", bus.out_valid, 0);
        #11 rst_n = 1'b1;

        // Combinational sweep with a=3, b=2.
        bus.a = 4'd3;
        bus.b = 4'd2;
        for (int i = 0; i < 7; i++) begin
            bus.op = 3'(i);
            #5;
            check_eq("comb_sweep", bus.result, sweep_exp[i]);
        end

        // Registered sweep.
        for (int i = 0; i < 7; i++) begin
            step(4'd3, 4'd2, 3'(i), 1'b1);
            if (i == 0) check_eq("add_flags", bus.flags_q, 4'b0000);
        end

        // Boundaries.
        step(4'd15, 4'd1, 3'd0, 1'b1);
        check_eq("add_wrap_res", bus.result_q, 4'd0);
        check_eq("add_wrap_flags", bus.flags_q, 4'b0011);
        step(4'd2, 4'd3, 3'd1, 1'b1);
        check_eq("sub_borrow_res", bus.result_q, 4'd15);
        check_eq("sub_borrow_flags", bus.flags_q, 4'b1000);
        step(4'd7, 4'd1, 3'd0, 1'b1);
        check_eq("add_ovf_res", bus.result_q, 4'd8);
        check_eq("add_ovf_flags", bus.flags_q, 4'b1100);
        step(4'd3, 4'd1, 3'd7, 1'b1);
`ifdef ALU_EXT_OPS_EN
        check_eq("op7_res", bus.result_q, 4'd6);
`else
        check_eq("op7_res", bus.result_q, 4'd0);
`endif
        check_eq("op7_flags", bus.flags_q, 4'b0000);

        // Hold: in_valid low for 3 cycles while inputs change.
        step(4'd5, 4'd6, 3'd0, 1'b1);
        step(4'd1, 4'd9, 3'd1, 1'b0);
        step(4'd14, 4'd7, 3'd4, 1'b0);
        step(4'd8, 4'd8, 3'd0, 1'b0);

        // Asynchronous reset between edges with a capture pending.
        step(4'd9, 4'd4, 3'd1, 1'b1);
        @(negedge clk);
        bus.a = 4'd6;
        bus.b = 4'd5;
        bus.op = 3'd0;
        bus.in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_result_q", bus.result_q, 0);
        check_eq("async_rst_flags_q", bus.flags_q, 0);
        check_eq("async_rst_out_valid", bus.out_valid, 0);
        bus.a = 4'd2;
        #1;
        check_eq("rst_comb_tracks", bus.result, 4'd7);
        @(posedge clk);
        #1;
        check_eq("rst_ignores_valid", bus.out_valid, 0);
        check_eq("rst_ignores_res", bus.result_q, 0);
        sb_q.delete();
        last_cap = '0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
